// File: rtl/pbpix_rr_arbiter.sv
// Round-robin arbiter merging NREQ pbpix producers into one tagged output register.
// Define PBPIX_ARB_ZERO_SKIP_EN to absorb zero-flagged beats at the arbiter and count them in skip_cnt.
module pbpix_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 16,
  parameter int IDW  = $clog2(NREQ),
  parameter int CW   = 16
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic [NREQ-1:0]    in_rdy,
  output logic [NREQ-1:0]    in_ack,
  input  logic [NREQ-1:0]    in_zero,
  input  logic [NREQ*DW-1:0] in_data,
  output logic               out_rdy,
  input  logic               out_ack,
  output logic               out_zero,
  output logic [DW-1:0]      out_data,
  output logic [IDW-1:0]     out_id
`ifdef PBPIX_ARB_ZERO_SKIP_EN
  ,
  output logic [CW-1:0]      skip_cnt
`endif
);

`ifdef PBPIX_ARB_ZERO_SKIP_EN
  localparam bit ZS = 1'b1;
`else
  localparam bit ZS = 1'b0;
`endif

  logic [IDW-1:0]  ptr;
  logic            load_ok;
  logic [NREQ-1:0] eligible;
  logic            gnt_vld;
  logic [IDW-1:0]  gnt_idx;
  logic [IDW:0]    cand;
  logic [NREQ-1:0] ack_vec;
  logic [DW-1:0]   sel_data;
  logic            sel_zero;
  logic            absorb;
  logic            load;

  assign load_ok = !out_rdy || out_ack;

  // Zero beats never touch the slot, so they stay eligible while it is full.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NREQ; i++) begin
      eligible[i] = in_rdy[i] && (load_ok || (ZS && in_zero[i]));
    end
  end

  // Search ptr, ptr+1, ... with an explicit wrap so non-power-of-two NREQ works.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) begin
        cand = cand - (IDW+1)'(NREQ);
      end
      if (!gnt_vld && eligible[cand[IDW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    sel_data = '0;
    sel_zero = 1'b0;
    ack_vec  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        sel_data = in_data[i*DW +: DW];
        sel_zero = in_zero[i];
      end
    end
    if (gnt_vld) begin
      ack_vec[gnt_idx] = 1'b1;
    end
  end

  // Only the output is gated; internal state is already held in reset.
  assign in_ack = ack_vec & {NREQ{i_rstn}};
  assign absorb = gnt_vld && ZS && sel_zero;
  assign load   = gnt_vld && !absorb;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      out_rdy  <= 1'b0;
      out_zero <= 1'b0;
      out_data <= '0;
      out_id   <= '0;
    end else if (load) begin
      out_rdy  <= 1'b1;
      out_zero <= ZS ? 1'b0 : sel_zero;
      out_data <= sel_data;
      out_id   <= gnt_idx;
    end else if (out_ack) begin
      out_rdy  <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      ptr <= '0;
    end else if (gnt_vld) begin
      ptr <= (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);
    end
  end

`ifdef PBPIX_ARB_ZERO_SKIP_EN
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      skip_cnt <= '0;
    end else if (absorb) begin
      skip_cnt <= skip_cnt + CW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pbpix_rr_arbiter.sv
// Self-checking bench for pbpix_rr_arbiter: directed scenarios plus random traffic
// against a round-robin reference model. Follows PBPIX_ARB_ZERO_SKIP_EN like the DUT.
module tb_pbpix_rr_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 16;
  localparam int IDW  = 2;
  localparam int CW   = 16;
`ifdef PBPIX_ARB_ZERO_SKIP_EN
  localparam bit ZS = 1'b1;
`else
  localparam bit ZS = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               i_rstn;
  logic [NREQ-1:0]    in_rdy, in_ack, in_zero;
  logic [NREQ*DW-1:0] in_data;
  logic               out_rdy, out_ack, out_zero;
  logic [DW-1:0]      out_data;
  logic [IDW-1:0]     out_id;
`ifdef PBPIX_ARB_ZERO_SKIP_EN
  logic [CW-1:0]      skip_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  int          m_ptr, m_id, m_skip;
  bit          m_rdy, m_zero;
  logic [DW-1:0] m_data;

  always #5 clk = ~clk;

  pbpix_rr_arbiter #(.NREQ(NREQ), .DW(DW), .IDW(IDW), .CW(CW)) dut (
    .i_clk(clk), .i_rstn(i_rstn),
    .in_rdy(in_rdy), .in_ack(in_ack), .in_zero(in_zero), .in_data(in_data),
    .out_rdy(out_rdy), .out_ack(out_ack), .out_zero(out_zero),
    .out_data(out_data), .out_id(out_id)
`ifdef PBPIX_ARB_ZERO_SKIP_EN
    , .skip_cnt(skip_cnt)
`endif
  );

  function automatic int cur_skip();
`ifdef PBPIX_ARB_ZERO_SKIP_EN
    return int'(skip_cnt);
`else
    return 0;
`endif
  endfunction

  function automatic void model_reset();
    m_ptr = 0; m_id = 0; m_skip = 0; m_rdy = 0; m_zero = 0; m_data = '0;
  endfunction

  // Winner under the round-robin rule for the currently driven inputs, or -1.
  function automatic int exp_grant();
    bit lok;
    int idx;
    lok = !m_rdy || out_ack;
    for (int k = 0; k < NREQ; k++) begin
      idx = (m_ptr + k) % NREQ;
      if (in_rdy[idx] && (lok || (ZS && in_zero[idx]))) return idx;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] ack_of(input int g);
    logic [NREQ-1:0] v;
    v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  function automatic void model_edge(input int g);
    bit loaded;
    loaded = 0;
    if (g >= 0) begin
      if (ZS && in_zero[g]) m_skip = (m_skip + 1) % (1 << CW);
      else begin
        m_data = in_data[g*DW +: DW];
        m_zero = in_zero[g];
        m_id   = g;
        m_rdy  = 1;
        loaded = 1;
      end
      m_ptr = (g + 1) % NREQ;
    end
    if (!loaded && out_ack) m_rdy = 0;
  endfunction

  task automatic drive(input logic [NREQ-1:0] rdy, input logic [NREQ-1:0] zero,
                       input logic [NREQ*DW-1:0] data, input logic ack);
    in_rdy = rdy; in_zero = zero; in_data = data; out_ack = ack;
  endtask

  task automatic advance();
    int g;
    g = exp_grant();
    @(posedge clk);
    model_edge(g);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_rstn = 1'b0;
    drive('0, '0, '0, 1'b0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    i_rstn = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    i_rstn = 1'b0;
    drive(4'b1111, 4'b0000, {16'h4444, 16'h3333, 16'h2222, 16'h1111}, 1'b1);
    #1;
    n_cmp++; if (in_ack !== 4'b0000) begin n_bad++; $display("FAIL reset_in_ack got=%b want=0000", in_ack); end
    n_cmp++; if (out_rdy !== 1'b0) begin n_bad++; $display("FAIL reset_out_rdy got=%b want=0", out_rdy); end
    n_cmp++; if (out_data !== 16'h0 || out_id !== 2'd0 || out_zero !== 1'b0) begin
      n_bad++; $display("FAIL reset_slot got data=%h id=%0d zero=%b want 0/0/0", out_data, out_id, out_zero);
    end
    n_cmp++; if (cur_skip() != 0) begin n_bad++; $display("FAIL reset_skip got=%0d want=0", cur_skip()); end
    model_reset();
    @(negedge clk);
    i_rstn = 1'b1;
  endtask

  task automatic test_round_robin();
    do_reset();
    drive(4'b1111, 4'b0000, {16'h1003, 16'h1002, 16'h1001, 16'h1000}, 1'b1);
    for (int n = 0; n < 10; n++) begin
      #1;
      n_cmp++; if (in_ack !== ack_of(n % NREQ)) begin
        n_bad++; $display("FAIL rr_ack[%0d] got=%b want=%b", n, in_ack, ack_of(n % NREQ));
      end
      n_cmp++; if (out_rdy !== (n != 0)) begin
        n_bad++; $display("FAIL rr_out_rdy[%0d] got=%b want=%b", n, out_rdy, n != 0);
      end
      if (n != 0) begin
        n_cmp++; if (out_id !== IDW'((n - 1) % NREQ) || out_data !== 16'h1000 + 16'((n - 1) % NREQ)) begin
          n_bad++; $display("FAIL rr_beat[%0d] got id=%0d data=%h want id=%0d", n, out_id, out_data, (n - 1) % NREQ);
        end
      end
      advance();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    drive(4'b0100, 4'b0000, {16'h0, 16'h00A5, 16'h0, 16'h0}, 1'b0);
    #1;
    n_cmp++; if (in_ack !== 4'b0100) begin n_bad++; $display("FAIL bp_first_ack got=%b want=0100", in_ack); end
    advance();
    drive(4'b0100, 4'b0000, {16'h0, 16'h1234, 16'h0, 16'h0}, 1'b0);
    for (int n = 0; n < 5; n++) begin
      #1;
      n_cmp++; if (out_rdy !== 1'b1 || out_data !== 16'h00A5 || out_id !== 2'd2) begin
        n_bad++; $display("FAIL bp_hold[%0d] got rdy=%b data=%h id=%0d want 1/00a5/2", n, out_rdy, out_data, out_id);
      end
      n_cmp++; if (in_ack !== 4'b0000) begin n_bad++; $display("FAIL bp_no_ack[%0d] got=%b want=0000", n, in_ack); end
      advance();
    end
    out_ack = 1'b1;
    #1;
    n_cmp++; if (in_ack !== 4'b0100) begin n_bad++; $display("FAIL bp_release_ack got=%b want=0100", in_ack); end
    advance();
    n_cmp++; if (out_rdy !== 1'b1 || out_data !== 16'h1234) begin
      n_bad++; $display("FAIL bp_second_beat got rdy=%b data=%h want 1/1234", out_rdy, out_data);
    end
  endtask

  task automatic test_alternate();
    int want [3] = '{1, 3, 1};
    do_reset();
    drive(4'b1010, 4'b0000, {16'hD3D3, 16'h0, 16'hB1B1, 16'h0}, 1'b1);
    for (int n = 0; n < 3; n++) begin
      #1;
      n_cmp++; if (in_ack !== ack_of(want[n])) begin
        n_bad++; $display("FAIL alt_grant[%0d] got=%b want=%b", n, in_ack, ack_of(want[n]));
      end
      advance();
    end
  endtask

  task automatic test_zero();
    do_reset();
`ifdef PBPIX_ARB_ZERO_SKIP_EN
    drive(4'b0010, 4'b0000, {16'h0, 16'h0, 16'h5A5A, 16'h0}, 1'b0);
    advance();
    drive(4'b0001, 4'b0001, {16'h0, 16'h0, 16'h0, 16'h0}, 1'b0);
    #1;
    n_cmp++; if (in_ack !== 4'b0001) begin n_bad++; $display("FAIL zs_ack got=%b want=0001", in_ack); end
    advance();
    n_cmp++; if (cur_skip() != 1) begin n_bad++; $display("FAIL zs_skip got=%0d want=1", cur_skip()); end
    n_cmp++; if (out_rdy !== 1'b1 || out_data !== 16'h5A5A || out_id !== 2'd1 || out_zero !== 1'b0) begin
      n_bad++; $display("FAIL zs_held got rdy=%b data=%h id=%0d zero=%b want 1/5a5a/1/0", out_rdy, out_data, out_id, out_zero);
    end
`else
    drive(4'b1000, 4'b1000, {16'h0, 16'h0, 16'h0, 16'h0}, 1'b1);
    #1;
    n_cmp++; if (in_ack !== 4'b1000) begin n_bad++; $display("FAIL nzs_ack got=%b want=1000", in_ack); end
    advance();
    n_cmp++; if (out_rdy !== 1'b1 || out_zero !== 1'b1 || out_id !== 2'd3 || out_data !== 16'h0) begin
      n_bad++; $display("FAIL nzs_fwd got rdy=%b zero=%b id=%0d data=%h want 1/1/3/0000", out_rdy, out_zero, out_id, out_data);
    end
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(4'b0010, 4'b0000, {16'h0, 16'h0, 16'hBEEF, 16'h0}, 1'b0);
    advance();
    drive(4'b0000, 4'b0000, '0, 1'b0);
    #1;
    n_cmp++; if (out_rdy !== 1'b1 || out_data !== 16'hBEEF) begin
      n_bad++; $display("FAIL mid_setup got rdy=%b data=%h want 1/beef", out_rdy, out_data);
    end
    i_rstn = 1'b0;
    #1;
    n_cmp++; if (out_rdy !== 1'b0 || out_data !== 16'h0 || out_id !== 2'd0 || cur_skip() != 0) begin
      n_bad++; $display("FAIL mid_async_clear got rdy=%b data=%h id=%0d skip=%0d want all 0", out_rdy, out_data, out_id, cur_skip());
    end
    model_reset();
    @(negedge clk);
    i_rstn = 1'b1;
    drive(4'b1100, 4'b0000, {16'h7777, 16'h6666, 16'h0, 16'h0}, 1'b1);
    #1;
    n_cmp++; if (in_ack !== 4'b0100) begin n_bad++; $display("FAIL mid_first_grant got=%b want=0100", in_ack); end
    advance();
  endtask

  task automatic test_random();
    bit            p_rdy  [NREQ];
    bit            p_zero [NREQ];
    logic [DW-1:0] p_data [NREQ];
    int            g;
    do_reset();
    for (int i = 0; i < NREQ; i++) begin p_rdy[i] = 0; p_zero[i] = 0; p_data[i] = '0; end
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!p_rdy[i] && $urandom_range(0, 2) != 0) begin
          p_rdy[i]  = 1;
          p_zero[i] = ($urandom_range(0, 3) == 0);
          p_data[i] = DW'($urandom);
        end
        in_rdy[i]  = p_rdy[i];
        in_zero[i] = p_zero[i];
        in_data[i*DW +: DW] = p_data[i];
      end
      out_ack = ($urandom_range(0, 3) != 0);
      #1;
      g = exp_grant();
      n_cmp++; if (in_ack !== ack_of(g)) begin
        n_bad++; $display("FAIL rnd_ack[%0d] got=%b want=%b", n, in_ack, ack_of(g));
      end
      n_cmp++; if (out_rdy !== m_rdy || out_data !== m_data || out_id !== IDW'(m_id) || out_zero !== m_zero) begin
        n_bad++; $display("FAIL rnd_slot[%0d] got rdy=%b data=%h id=%0d zero=%b want %b/%h/%0d/%b",
                          n, out_rdy, out_data, out_id, out_zero, m_rdy, m_data, m_id, m_zero);
      end
      n_cmp++; if (cur_skip() != m_skip) begin
        n_bad++; $display("FAIL rnd_skip[%0d] got=%0d want=%0d", n, cur_skip(), m_skip);
      end
      @(posedge clk);
      model_edge(g);
      if (g >= 0) p_rdy[g] = 0;
      @(negedge clk);
    end
  endtask

  initial begin
    i_rstn = 1'b0;
    drive('0, '0, '0, 1'b0);
    model_reset();
    test_reset();
    test_round_robin();
    test_backpressure();
    test_alternate();
    test_zero();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
